aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_pkg.sv | 37 +++
 rtl/aes_round_ctrl.sv | 133 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// AES round controller shared types and constants.
// Round counts per key length and FSM state encoding.
package aes_package;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_OUT
  } aes_round_state_t;

  localparam logic [1:0] KEY_128  = 2'b00;
  localparam logic [1:0] KEY_192  = 2'b01;
  localparam logic [1:0] KEY_256  = 2'b10;
  localparam logic [1:0] KEY_RSVD = 2'b11;

  localparam logic [3:0] AES_NR_128 = 4'd10;
  localparam logic [3:0] AES_NR_192 = 4'd12;
  localparam logic [3:0] AES_NR_256 = 4'd14;

  // Reserved encoding falls back to AES-128 rounds.
  function automatic logic [3:0] nr_of(
    input logic [1:0] key_len
  );
    logic [3:0] nr;
    nr = AES_NR_128;
    unique case (1'b1)
      (key_len == KEY_128):  nr = AES_NR_128;
      (key_len == KEY_192):  nr = AES_NR_192;
      (key_len == KEY_256):  nr = AES_NR_256;
      (key_len == KEY_RSVD): nr = AES_NR_128;
      default:               nr = AES_NR_128;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencing controller: accepts a block, walks the
// round keys 0..Nr and hands the ciphertext downstream.
module aes_round_ctrl
  import aes_package::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [1:0]       key_len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             rk_req_o,
  output logic [3:0]       rk_idx_o,
  input  logic             rk_gnt_i,
  output logic             load_state_o,
  output logic             round_en_o,
  output logic [3:0]       round_idx_o,
  output logic             last_round_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  output logic             cfg_err_o
);

  aes_round_state_t r_state;
  aes_round_state_t w_state_nxt;

  logic [3:0]       r_rcnt;
  logic [3:0]       w_rcnt_nxt;
  logic [3:0]       r_nr;
  logic [3:0]       w_nr_nxt;
  logic [CNT_W-1:0] r_blk;
  logic [CNT_W-1:0] w_blk_nxt;
  logic             r_err;
  logic             w_err_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rcnt  <= 4'd0;
      r_nr    <= AES_NR_128;
      r_blk   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_nr    <= w_nr_nxt;
      r_blk   <= w_blk_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rcnt_nxt   = r_rcnt;
    w_nr_nxt     = r_nr;
    w_blk_nxt    = r_blk;
    w_err_nxt    = r_err;
    in_ready_o   = 1'b0;
    rk_req_o     = 1'b0;
    rk_idx_o     = 4'd0;
    load_state_o = 1'b0;
    round_en_o   = 1'b0;
    round_idx_o  = 4'd0;
    last_round_o = 1'b0;
    out_valid_o  = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        busy_o     = 1'b0;
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_nr_nxt    = nr_of(key_len_i);
          w_err_nxt   = r_err | (key_len_i == KEY_RSVD);
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        rk_req_o = 1'b1;
        if (rk_gnt_i) begin
          load_state_o = 1'b1;
          w_rcnt_nxt   = 4'd1;
          w_state_nxt  = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_req_o     = 1'b1;
        rk_idx_o     = r_rcnt;
        round_idx_o  = r_rcnt;
        last_round_o = (r_rcnt == r_nr);
        round_en_o   = rk_gnt_i;
        if (rk_gnt_i) begin
          if (r_rcnt == r_nr) begin
            w_rcnt_nxt  = 4'd0;
            w_state_nxt = S_OUT;
          end else begin
            w_rcnt_nxt = r_rcnt + 4'd1;
          end
        end
      end
      S_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          done_o      = 1'b1;
          w_blk_nxt   = r_blk + CNT_W'(1);
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Clear overrides any transition and suppresses the completion pulse.
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_rcnt_nxt  = 4'd0;
      w_blk_nxt   = '0;
      w_err_nxt   = 1'b0;
      done_o      = 1'b0;
    end
  end

  assign blk_cnt_o = r_blk;
  assign cfg_err_o = r_err;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl against a
// grant-counting transaction model.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] key_len_i = 2'b00;
  logic       in_valid_i = 1'b0;
  logic       rk_gnt_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic       in_ready_o;
  logic       rk_req_o;
  logic [3:0] rk_idx_o;
  logic       load_state_o;
  logic       round_en_o;
  logic [3:0] round_idx_o;
  logic       last_round_o;
  logic       out_valid_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] blk_cnt_o;
  logic       cfg_err_o;

  int total = 0;
  int bad = 0;

  aes_round_ctrl #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .key_len_i    (key_len_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .rk_req_o     (rk_req_o),
    .rk_idx_o     (rk_idx_o),
    .rk_gnt_i     (rk_gnt_i),
    .load_state_o (load_state_o),
    .round_en_o   (round_en_o),
    .round_idx_o  (round_idx_o),
    .last_round_o (last_round_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .blk_cnt_o    (blk_cnt_o),
    .cfg_err_o    (cfg_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int nr_for(input logic [1:0] k);
    case (k)
      2'b01:   return 12;
      2'b10:   return 14;
      default: return 10;
    endcase
  endfunction

  // Model: busy flag plus number of key grants consumed in this block.
  // Grants 0 -> loading, 1..Nr -> rounds, Nr+1 -> output pending.
  bit m_busy = 0;
  int m_g = 0;
  int m_nr = 10;
  int m_cnt = 0;
  bit m_err = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_g = 0; m_nr = 10; m_cnt = 0; m_err = 0;
    end else if (clear) begin
      m_busy = 0; m_g = 0; m_cnt = 0; m_err = 0;
    end else if (!m_busy) begin
      if (in_valid_i) begin
        m_busy = 1;
        m_g = 0;
        m_nr = nr_for(key_len_i);
        if (key_len_i == 2'b11) m_err = 1;
      end
    end else if (m_g <= m_nr) begin
      if (rk_gnt_i) m_g++;
    end else if (out_ready_i) begin
      m_busy = 0;
      m_cnt = (m_cnt + 1) % 16;
    end
  end

  always @(negedge clk) begin
    int ph;
    if (!m_busy) ph = 0;
    else if (m_g == 0) ph = 1;
    else if (m_g <= m_nr) ph = 2;
    else ph = 3;
    check("in_ready", in_ready_o, ph == 0);
    check("rk_req", rk_req_o, ph == 1 || ph == 2);
    check("rk_idx", rk_idx_o, ph == 2 ? m_g : 0);
    check("load_state", load_state_o, ph == 1 && rk_gnt_i);
    check("round_en", round_en_o, ph == 2 && rk_gnt_i);
    check("round_idx", round_idx_o, ph == 2 ? m_g : 0);
    check("last_round", last_round_o, ph == 2 && m_g == m_nr);
    check("out_valid", out_valid_o, ph == 3);
    check("busy", busy_o, ph != 0);
    check("done", done_o, ph == 3 && out_ready_i && !clear);
    check("blk_cnt", blk_cnt_o, m_cnt);
    check("cfg_err", cfg_err_o, m_err);
  end

  // One block from IDLE; cycle k=0 is the acceptance cycle.
  task automatic run_block(
    input  logic [1:0] key,
    input  int stall_at, input int stall_n,
    input  int bp_n, input bit vhold,
    output int lat, output int nen, output int nlast,
    output int ndone, output int nout, output int sidx
  );
    bit hs;
    lat = -1; nen = 0; nlast = 0; ndone = 0; nout = 0; sidx = -1;
    hs = 0;
    for (int k = 0; k < 80 && !hs; k++) begin
      key_len_i = key;
      in_valid_i = (k == 0) || vhold;
      rk_gnt_i = !(stall_n > 0 && k >= stall_at &&
                   k < stall_at + stall_n);
      out_ready_i = (nout >= bp_n);
      @(negedge clk);
      if (out_valid_o && lat < 0) lat = k;
      if (round_en_o) nen++;
      if (last_round_o) nlast++;
      if (done_o) ndone++;
      if (stall_n > 0 && k == stall_at + stall_n - 1) sidx = round_idx_o;
      if (out_valid_o && out_ready_i) hs = 1;
      if (out_valid_o) nout++;
      @(posedge clk);
      #1;
    end
    in_valid_i = 0;
    if (!hs) check("block_timeout", 0, 1);
  endtask

  initial begin
    int lat, nen, nlast, ndone, nout, sidx;
    bit seen;
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_blk_cnt", blk_cnt_o, 0);

    run_block(2'b00, 0, 0, 0, 0, lat, nen, nlast, ndone, nout, sidx);
    check("aes128_latency", lat, 12);
    check("aes128_rounds", nen, 10);
    check("aes128_last", nlast, 1);
    check("aes128_done", ndone, 1);
    check("aes128_blk", blk_cnt_o, 1);

    run_block(2'b10, 0, 0, 0, 0, lat, nen, nlast, ndone, nout, sidx);
    check("aes256_latency", lat, 16);
    check("aes256_rounds", nen, 14);

    run_block(2'b01, 0, 0, 0, 0, lat, nen, nlast, ndone, nout, sidx);
    check("aes192_latency", lat, 14);
    check("aes192_rounds", nen, 12);

    run_block(2'b11, 0, 0, 0, 0, lat, nen, nlast, ndone, nout, sidx);
    check("rsvd_latency", lat, 12);
    check("rsvd_rounds", nen, 10);
    check("rsvd_cfg_err", cfg_err_o, 1);

    run_block(2'b00, 6, 3, 0, 0, lat, nen, nlast, ndone, nout, sidx);
    check("stall_latency", lat, 15);
    check("stall_rounds", nen, 10);
    check("stall_idx", sidx, 5);
    check("cfg_err_sticky", cfg_err_o, 1);

    run_block(2'b00, 0, 0, 4, 1, lat, nen, nlast, ndone, nout, sidx);
    check("bp_latency", lat, 12);
    check("bp_out_cycles", nout, 5);
    check("bp_done", ndone, 1);
    check("bp_blk", blk_cnt_o, 6);

    // Clear at round 7.
    seen = 0;
    rk_gnt_i = 1; out_ready_i = 1; key_len_i = 2'b00;
    for (int k = 0; k < 9; k++) begin
      in_valid_i = (k == 0);
      clear = (k == 8);
      @(negedge clk);
      if (done_o) seen = 1;
      if (k == 8) check("clear_at_round", round_idx_o, 7);
      @(posedge clk);
      #1;
    end
    clear = 0;
    @(negedge clk);
    check("clear_idle", busy_o, 0);
    check("clear_in_ready", in_ready_o, 1);
    check("clear_blk", blk_cnt_o, 0);
    check("clear_err", cfg_err_o, 0);
    check("clear_no_done", seen, 0);
    @(posedge clk);
    #1;

    for (int b = 0; b < 17; b++)
      run_block(2'b00, 0, 0, 0, 0, lat, nen, nlast, ndone, nout, sidx);
    check("wrap_blk", blk_cnt_o, 1);

    // Reset while holding in OUT.
    out_ready_i = 0; rk_gnt_i = 1;
    in_valid_i = 1;
    @(posedge clk);
    #1 in_valid_i = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid_o) seen = 1;
    end
    check("rst_reach_out", seen, 1);
    #1 reset_n = 0;
    #1;
    check("arst_out_valid", out_valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_blk", blk_cnt_o, 0);
    check("arst_rk_req", rk_req_o, 0);
    check("arst_done", done_o, 0);
    check("arst_in_ready", in_ready_o, 1);
    @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
